// File: rtl/k6502_oam_dma.sv
// rtl/k6502_oam_dma.sv - 256-byte OAM DMA engine that halts the CPU and copies page {page,00..FF} to DEST_ADDR
module k6502_oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  output logic        rdy,
  output logic        dma_en,
  output logic [15:0] dma_a,
  output logic        dma_rw,
  output logic [7:0]  dma_dout,
  input  logic [7:0]  dma_din,
  output logic        busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;

  logic [2:0] state;
  logic       par;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] latch;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      par   <= 1'b0;
      page  <= 8'h00;
      idx   <= 8'h00;
      latch <= 8'h00;
    end else begin
      par <= ~par;
      case (state)
        S_IDLE: begin
          // Only a CPU write starts a transfer; reads of the trigger address are harmless.
          if (!cpu_rw && cpu_a == TRIG_ADDR) begin
            page  <= cpu_d;
            idx   <= 8'h00;
            state <= S_HALT;
          end
        end
        S_HALT: begin
          // An odd-phase exit costs one extra cycle so reads line up with the bus phase.
          state <= par ? S_ALIGN : S_RD;
        end
        S_ALIGN: begin
          state <= S_RD;
        end
        S_RD: begin
          latch <= dma_din;
          state <= S_WR;
        end
        S_WR: begin
          if (idx == 8'hFF) begin
            state <= S_IDLE;
          end else begin
            idx   <= idx + 8'h01;
            state <= S_RD;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    rdy      = (state == S_IDLE);
    busy     = (state != S_IDLE);
    dma_en   = 1'b0;
    dma_rw   = 1'b1;
    dma_a    = 16'h0000;
    dma_dout = 8'h00;
    if (state == S_RD) begin
      dma_en = 1'b1;
      dma_a  = {page, idx};
    end else if (state == S_WR) begin
      dma_en   = 1'b1;
      dma_rw   = 1'b0;
      dma_a    = DEST_ADDR;
      dma_dout = latch;
    end
  end

endmodule

// File: tb/tb_k6502_oam_dma.sv
// tb/tb_k6502_oam_dma.sv - scoreboard bench for k6502_oam_dma
module tb_k6502_oam_dma;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        cpu_rw;
  logic        rdy;
  logic        dma_en;
  logic [15:0] dma_a;
  logic        dma_rw;
  logic [7:0]  dma_dout;
  logic [7:0]  dma_din;
  logic        busy;

  k6502_oam_dma dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .cpu_rw   (cpu_rw),
    .rdy      (rdy),
    .dma_en   (dma_en),
    .dma_a    (dma_a),
    .dma_rw   (dma_rw),
    .dma_dout (dma_dout),
    .dma_din  (dma_din),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  assign dma_din = mem[dma_a];

  int total = 0;
  int bad   = 0;

  logic [15:0] rd_q [$];
  logic [7:0]  wr_q [$];

  logic        tb_par;
  int          cyc = 0;
  int          trig_cyc;
  int          first_rd_cyc;
  logic        first_rd_pending = 1'b0;
  int          low_run = 0;
  int          last_low = 0;
  int          wr_count = 0;
  logic [7:0]  last_wr_data;
  logic        seen_zero = 1'b0;

  always @(posedge clk) begin
    tb_par <= !rst_n ? 1'b0 : ~tb_par;
    cyc    <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every DMA read/write is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n && dma_en) begin
      if (dma_a == 16'h0000) seen_zero = 1'b1;
      if (dma_rw) begin
        if (first_rd_pending) begin
          first_rd_cyc     = cyc;
          first_rd_pending = 1'b0;
        end
        if (rd_q.size() == 0) chk("rd_unexpected", {16'h0, dma_a}, 32'hFFFF_FFFF);
        else chk("rd_addr", {16'h0, dma_a}, {16'h0, rd_q.pop_front()});
      end else begin
        wr_count++;
        last_wr_data = dma_dout;
        if (wr_q.size() == 0) chk("wr_unexpected", {24'h0, dma_dout}, 32'hFFFF_FFFF);
        else begin
          chk("wr_addr", {16'h0, dma_a}, 32'h0000_2004);
          chk("wr_data", {24'h0, dma_dout}, {24'h0, wr_q.pop_front()});
        end
      end
    end
    if (!rdy) low_run++;
    else if (low_run > 0) begin
      last_low = low_run;
      low_run  = 0;
    end
  end

  int exp_len;
  int exp_lat;

  task automatic trigger(input logic [7:0] pg, input logic want_align);
    logic [7:0] ib;
    @(negedge clk);
    if (tb_par != (want_align ? 1'b0 : 1'b1)) @(negedge clk);
    cpu_a  = 16'h4014;
    cpu_d  = pg;
    cpu_rw = 1'b0;
    trig_cyc = cyc;
    exp_len  = want_align ? 514 : 513;
    exp_lat  = want_align ? 3 : 2;
    for (int i = 0; i < 256; i++) begin
      ib = i[7:0];
      rd_q.push_back({pg, ib});
      wr_q.push_back(mem[{pg, ib}]);
    end
    first_rd_pending = 1'b1;
    @(negedge clk);
    cpu_rw = 1'b1;
    cpu_a  = 16'h0000;
    chk("trig_busy", {31'h0, busy}, 32'h1);
    chk("trig_rdy", {31'h0, rdy}, 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
    @(negedge clk);
  endtask

  task automatic wait_rd(input logic [15:0] a);
    int n;
    n = 0;
    while (!(dma_en && dma_rw && dma_a == a) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_timeout", {16'h0, dma_a}, {16'h0, a});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst_n  = 1'b0;
    cpu_a  = 16'h0000;
    cpu_d  = 8'h00;
    cpu_rw = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {31'h0, rdy}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_dma_en", {31'h0, dma_en}, 32'h0);
    chk("rst_dma_rw", {31'h0, dma_rw}, 32'h1);
    chk("rst_dma_a", {16'h0, dma_a}, 32'h0);
    chk("rst_dma_dout", {24'h0, dma_dout}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Page 02 without the alignment cycle.
    trigger(8'h02, 1'b0);
    wait_idle("idle_t1");
    chk("t1_low_len", last_low, exp_len);
    chk("t1_first_rd_lat", first_rd_cyc - trig_cyc, exp_lat);
    chk("t1_queue_empty", wr_q.size(), 0);

    // Page 02 with the alignment cycle.
    trigger(8'h02, 1'b1);
    wait_idle("idle_t2");
    chk("t2_low_len", last_low, exp_len);
    chk("t2_first_rd_lat", first_rd_cyc - trig_cyc, exp_lat);
    chk("t2_queue_empty", wr_q.size(), 0);

    // Non-trigger accesses.
    cpu_a = 16'h4014; cpu_rw = 1'b1; cpu_d = 8'h02;
    @(negedge clk);
    chk("rd4014_busy", {31'h0, busy}, 32'h0);
    chk("rd4014_rdy", {31'h0, rdy}, 32'h1);
    cpu_a = 16'h4015; cpu_rw = 1'b0;
    @(negedge clk);
    chk("wr4015_busy", {31'h0, busy}, 32'h0);
    cpu_rw = 1'b1; cpu_a = 16'h0000;
    @(negedge clk);
    chk("wr4015_busy2", {31'h0, busy}, 32'h0);
    chk("wr4015_rdy", {31'h0, rdy}, 32'h1);

    // Retrigger while busy must be ignored.
    trigger(8'h02, 1'b0);
    wait_rd(16'h0240);
    cpu_a = 16'h4014; cpu_d = 8'h05; cpu_rw = 1'b0;
    repeat (2) @(negedge clk);
    cpu_rw = 1'b1; cpu_a = 16'h0000;
    wait_idle("idle_t3");
    chk("t3_low_len", last_low, exp_len);
    chk("t3_queue_empty", wr_q.size(), 0);

    // Reset during WR at idx 80 aborts the transfer.
    trigger(8'h03, 1'b0);
    wait_rd(16'h0380);
    @(negedge clk);
    chk("t4_in_wr", {31'h0, dma_rw}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rd_q.delete();
    wr_q.delete();
    wr_count = 0;
    @(negedge clk);
    chk("t4_rst_rdy", {31'h0, rdy}, 32'h1);
    chk("t4_rst_dma_en", {31'h0, dma_en}, 32'h0);
    chk("t4_rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    chk("t4_no_writes", wr_count, 0);
    chk("t4_still_idle", {31'h0, busy}, 32'h0);

    // Top page: last byte from FFFF, no wrap to 0000.
    mem[16'hFFFF] = 8'hA5;
    seen_zero = 1'b0;
    trigger(8'hFF, 1'b1);
    wait_idle("idle_t5");
    chk("t5_last_data", {24'h0, last_wr_data}, 32'hA5);
    chk("t5_no_zero_access", {31'h0, seen_zero}, 32'h0);
    chk("t5_low_len", last_low, exp_len);
    chk("t5_queue_empty", rd_q.size(), 0);
    repeat (4) @(negedge clk);
    chk("t5_final_idle", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
